// File: rtl/simple_event_monitor_if.sv
// Window report port for simple_event_monitor: valid/ready handshake plus counter payload.
// rpt_falls exists only when SIMPLE_MON_FALL_EN is defined.
interface simple_event_monitor_if #(
    parameter int CNT_W = 16
);
    logic             rpt_valid;
    logic             rpt_ready;
    logic [CNT_W-1:0] rpt_edges;
    logic [CNT_W-1:0] rpt_high;
    logic             rpt_overflow;
`ifdef SIMPLE_MON_FALL_EN
    logic [CNT_W-1:0] rpt_falls;

    modport master (
        output rpt_valid, rpt_edges, rpt_high, rpt_overflow, rpt_falls,
        input  rpt_ready
    );
    modport slave (
        input  rpt_valid, rpt_edges, rpt_high, rpt_overflow, rpt_falls,
        output rpt_ready
    );
`else
    modport master (
        output rpt_valid, rpt_edges, rpt_high, rpt_overflow,
        input  rpt_ready
    );
    modport slave (
        input  rpt_valid, rpt_edges, rpt_high, rpt_overflow,
        output rpt_ready
    );
`endif
endinterface

// File: rtl/simple_event_monitor.sv
// Synchronises f, counts rising edges and high cycles over fixed windows, reports per window.
// Optional falling-edge counter enabled by defining SIMPLE_MON_FALL_EN.
module simple_event_monitor #(
    parameter int CNT_W       = 16,
    parameter int WIN_LEN     = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_in,
    input  logic                  enable,
    simple_event_monitor_if.master rpt
);
    localparam int WCNT_W = $clog2(WIN_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [WCNT_W-1:0] WCNT_END = WCNT_W'(WIN_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_REPORT
    } state_t;

    state_t              r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                r_f_prev;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [CNT_W-1:0]    r_edges;
    logic [CNT_W-1:0]    r_high;
    logic                r_ovf;
    logic                r_rpt_valid;
    logic [CNT_W-1:0]    r_rpt_edges;
    logic [CNT_W-1:0]    r_rpt_high;
    logic                r_rpt_ovf;

    logic                w_f_s;
    logic                w_rise;
    logic [CNT_W-1:0]    w_edges_nxt;
    logic [CNT_W-1:0]    w_high_nxt;
    logic                w_ovf_nxt;
    logic                w_win_end;
`ifdef SIMPLE_MON_FALL_EN
    logic [CNT_W-1:0]    r_falls;
    logic [CNT_W-1:0]    r_rpt_falls;
    logic                w_fall;
    logic [CNT_W-1:0]    w_falls_nxt;
`endif

    assign w_f_s     = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_f_s & ~r_f_prev;
    assign w_win_end = (r_wcnt == WCNT_END);
`ifdef SIMPLE_MON_FALL_EN
    assign w_fall    = ~w_f_s & r_f_prev;
`endif

    // Saturating increments; an attempted increment at max raises the window's sticky overflow
    always_comb begin
        w_edges_nxt = r_edges;
        w_high_nxt  = r_high;
        w_ovf_nxt   = r_ovf;
        if (w_rise) begin
            if (r_edges == CNT_MAX) w_ovf_nxt = 1'b1;
            else                    w_edges_nxt = r_edges + CNT_W'(1);
        end
        if (w_f_s) begin
            if (r_high == CNT_MAX) w_ovf_nxt = 1'b1;
            else                   w_high_nxt = r_high + CNT_W'(1);
        end
`ifdef SIMPLE_MON_FALL_EN
        w_falls_nxt = r_falls;
        if (w_fall) begin
            if (r_falls == CNT_MAX) w_ovf_nxt = 1'b1;
            else                    w_falls_nxt = r_falls + CNT_W'(1);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sync      <= '0;
            r_f_prev    <= 1'b0;
            r_wcnt      <= '0;
            r_edges     <= '0;
            r_high      <= '0;
            r_ovf       <= 1'b0;
            r_rpt_valid <= 1'b0;
            r_rpt_edges <= '0;
            r_rpt_high  <= '0;
            r_rpt_ovf   <= 1'b0;
`ifdef SIMPLE_MON_FALL_EN
            r_falls     <= '0;
            r_rpt_falls <= '0;
`endif
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], f_in};
            r_f_prev <= w_f_s;
            case (r_state)
                S_IDLE: begin
                    r_rpt_valid <= 1'b0;
                    if (enable) begin
                        r_wcnt  <= '0;
                        r_edges <= '0;
                        r_high  <= '0;
                        r_ovf   <= 1'b0;
`ifdef SIMPLE_MON_FALL_EN
                        r_falls <= '0;
`endif
                        r_state <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_edges <= w_edges_nxt;
                        r_high  <= w_high_nxt;
                        r_ovf   <= w_ovf_nxt;
                        r_wcnt  <= r_wcnt + WCNT_W'(1);
`ifdef SIMPLE_MON_FALL_EN
                        r_falls <= w_falls_nxt;
`endif
                        // Last window cycle: latch the updated counts so this sample is included
                        if (w_win_end) begin
                            r_rpt_edges <= w_edges_nxt;
                            r_rpt_high  <= w_high_nxt;
                            r_rpt_ovf   <= w_ovf_nxt;
`ifdef SIMPLE_MON_FALL_EN
                            r_rpt_falls <= w_falls_nxt;
`endif
                            r_rpt_valid <= 1'b1;
                            r_state     <= S_REPORT;
                        end
                    end
                end
                S_REPORT: begin
                    if (rpt.rpt_ready) begin
                        r_rpt_valid <= 1'b0;
                        r_wcnt      <= '0;
                        r_edges     <= '0;
                        r_high      <= '0;
                        r_ovf       <= 1'b0;
`ifdef SIMPLE_MON_FALL_EN
                        r_falls     <= '0;
`endif
                        r_state     <= enable ? S_COUNT : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rpt.rpt_valid    = r_rpt_valid;
    assign rpt.rpt_edges    = r_rpt_edges;
    assign rpt.rpt_high     = r_rpt_high;
    assign rpt.rpt_overflow = r_rpt_ovf;
`ifdef SIMPLE_MON_FALL_EN
    assign rpt.rpt_falls    = r_rpt_falls;
`endif

endmodule
